bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bin_to_bcd_seq_if.sv | 32 +++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 104 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helper for the binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned ADJ_THRESH = 5;
    localparam int unsigned ADJ_ADD    = 3;
    localparam int unsigned XS3_OFFSET = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Excess-3 code of one BCD digit
    function automatic logic [DIGIT_W-1:0] xs3_digit(input logic [DIGIT_W-1:0] d);
        return d + DIGIT_W'(XS3_OFFSET);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready bus of bin_to_bcd_seq; out_xs3 exists only when BIN2BCD_XS3_EN is defined.
interface bin_to_bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) ();

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;

    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [BCD_W-1:0] out_bcd;
    logic             ovf;
`ifdef BIN2BCD_XS3_EN
    logic [BCD_W-1:0] out_xs3;

    modport master (output in_valid, in_bin, out_ready,
                    input  in_ready, out_valid, out_bcd, ovf, out_xs3);
    modport slave  (input  in_valid, in_bin, out_ready,
                    output in_ready, out_valid, out_bcd, ovf, out_xs3);
`else
    modport master (output in_valid, in_bin, out_ready,
                    input  in_ready, out_valid, out_bcd, ovf);
    modport slave  (input  in_valid, in_bin, out_ready,
                    output in_ready, out_valid, out_bcd, ovf);
`endif

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= DIGIT_W'(ADJ_THRESH)) ? digit + DIGIT_W'(ADJ_ADD) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with valid/ready on both sides.
// Optional BIN2BCD_XS3_EN adds a registered excess-3 copy of the result.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input logic              clk,
    input logic              rst_n,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [BIN_W-1:0]   sr;
    logic [CNT_W-1:0]   count;
    logic               ovf_acc;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]   bcd_next;
    logic               carry_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (acc[g*DIGIT_W +: DIGIT_W]),
            .adjusted (acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Top bit of the adjusted accumulator leaves the result; anything nonzero there is overflow
    assign carry_out = acc_adj[BCD_W-1];
    assign shifted   = {acc_adj[BCD_W-2:0], sr, 1'b0};
    assign bcd_next  = shifted[BCD_W+BIN_W-1 -: BCD_W];

`ifdef BIN2BCD_XS3_EN
    logic [BCD_W-1:0] xs3_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_xs3
        assign xs3_next[g*DIGIT_W +: DIGIT_W] = xs3_digit(bcd_next[g*DIGIT_W +: DIGIT_W]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_bcd   <= '0;
            bus.ovf       <= 1'b0;
            acc           <= '0;
            sr            <= '0;
            count         <= '0;
            ovf_acc       <= 1'b0;
`ifdef BIN2BCD_XS3_EN
            bus.out_xs3   <= {DIGITS{DIGIT_W'(XS3_OFFSET)}};
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr           <= bus.in_bin;
                        acc          <= '0;
                        ovf_acc      <= 1'b0;
                        count        <= CNT_W'(BIN_W);
                        bus.in_ready <= 1'b0;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, sr} <= shifted;
                    ovf_acc   <= ovf_acc | carry_out;
                    count     <= count - CNT_W'(1);
                    // Result is published on the last shift edge, so out_valid rises BIN_W cycles after accept
                    if (count == CNT_W'(1)) begin
                        bus.out_valid <= 1'b1;
                        bus.out_bcd   <= bcd_next;
                        bus.ovf       <= ovf_acc | carry_out;
`ifdef BIN2BCD_XS3_EN
                        bus.out_xs3   <= xs3_next;
`endif
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: a 3-digit and a 2-digit converter share stimulus; results compared to an arithmetic model.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) ia ();
    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) ib ();

    assign ib.in_valid  = ia.in_valid;
    assign ib.in_bin    = ia.in_bin;
    assign ib.out_ready = ia.out_ready;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, least significant digit in bits [3:0]
    function automatic logic [11:0] bcd_ref(input int v, input int digits);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] xs3_ref(input logic [11:0] b, input int digits);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < digits; i++) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        return r;
    endfunction

    task automatic check_results(input string tag, input int v);
        logic [11:0] ea;
        logic [11:0] eb;
        ea = bcd_ref(v, 3);
        eb = bcd_ref(v, 2);
        check_eq({tag, "_valid_a"}, 32'(ia.out_valid), 32'd1);
        check_eq({tag, "_valid_b"}, 32'(ib.out_valid), 32'd1);
        check_eq({tag, "_bcd_a"}, 32'(ia.out_bcd), 32'(ea));
        check_eq({tag, "_ovf_a"}, 32'(ia.ovf), 32'(v > 999));
        check_eq({tag, "_bcd_b"}, 32'(ib.out_bcd), 32'(eb[7:0]));
        check_eq({tag, "_ovf_b"}, 32'(ib.ovf), 32'(v > 99));
        check_eq({tag, "_in_ready"}, 32'(ia.in_ready), 32'd0);
`ifdef BIN2BCD_XS3_EN
        check_eq({tag, "_xs3_a"}, 32'(ia.out_xs3), 32'(xs3_ref(ea, 3)));
        begin
            logic [11:0] xb;
            xb = xs3_ref(eb, 2);
            check_eq({tag, "_xs3_b"}, 32'(ib.out_xs3), 32'(xb[7:0]));
        end
`endif
    endtask

    task automatic wait_accept(input logic [7:0] v);
        int n;
        @(negedge clk);
        ia.in_valid  = 1'b1;
        ia.in_bin    = v;
        ia.out_ready = 1'b0;
        n = 0;
        while (!ia.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_ready", 32'(ia.in_ready), 32'd1);
        @(posedge clk);
    endtask

    // One conversion: accept, measure latency, check, hold under backpressure, then release
    task automatic convert(input logic [7:0] v, input int hold, input bit keep, input logic [7:0] nxt);
        int n;
        logic [11:0] ea;
        wait_accept(v);
        #1;
        ia.in_valid = keep;
        ia.in_bin   = nxt;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ia.out_valid && n < 40);
        check_eq("latency", 32'(n), 32'd8);
        check_results("done", int'(v));
        ea = bcd_ref(int'(v), 3);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(ia.out_valid), 32'd1);
            check_eq("hold_bcd", 32'(ia.out_bcd), 32'(ea));
            check_eq("hold_in_ready", 32'(ia.in_ready), 32'd0);
        end
        ia.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ia.out_ready = 1'b0;
        check_eq("release_valid", 32'(ia.out_valid), 32'd0);
        check_eq("release_in_ready", 32'(ia.in_ready), 32'd1);
        check_eq("release_bcd_kept", 32'(ia.out_bcd), 32'(ea));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        ia.in_valid  = 1'b0;
        ia.in_bin    = '0;
        ia.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 32'(ia.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(ia.out_valid), 32'd0);
        check_eq("rst_bcd", 32'(ia.out_bcd), 32'h000);
        check_eq("rst_ovf", 32'(ia.ovf), 32'd0);
        check_eq("rst_bcd_b", 32'(ib.out_bcd), 32'h00);
`ifdef BIN2BCD_XS3_EN
        check_eq("rst_xs3", 32'(ia.out_xs3), 32'h333);
        check_eq("rst_xs3_b", 32'(ib.out_xs3), 32'h33);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(ia.in_ready), 32'd1);
        check_eq("post_rst_out_valid", 32'(ia.out_valid), 32'd0);
        check_eq("post_rst_bcd", 32'(ia.out_bcd), 32'h000);

        convert(8'd255, 0, 1'b0, 8'd0);
        convert(8'd0,   0, 1'b0, 8'd0);
        convert(8'd9,   0, 1'b0, 8'd0);
        convert(8'd100, 1, 1'b0, 8'd0);
        convert(8'd200, 0, 1'b0, 8'd0);
        convert(8'd199, 2, 1'b0, 8'd0);
        convert(8'd99,  0, 1'b0, 8'd0);
        convert(8'd37,  0, 1'b0, 8'd0);
        convert(8'd123, 5, 1'b1, 8'd42);
        convert(8'd42,  0, 1'b0, 8'd0);

        // Reset during the 4th shift cycle discards the conversion
        wait_accept(8'd77);
        #1;
        ia.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 32'(ia.in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(ia.out_valid), 32'd0);
        check_eq("midrst_bcd", 32'(ia.out_bcd), 32'h000);
        check_eq("midrst_ovf", 32'(ib.ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        convert(8'd58, 0, 1'b0, 8'd0);

        for (int k = 0; k < 40; k++) begin
            convert(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0, 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
